// File: rtl/mux24_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux24_pkg
// Purpose  : Shared constants and sequencer state type for the mux24 path.
// Revision : 1.0 - initial release
// ============================================================================
package mux24_pkg;

    localparam int SEL_W  = 4;
    localparam int DATA_W = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mux24.sv
`default_nettype none
// ============================================================================
// Module   : mux24
// Purpose  : 2**SEL_W : 1 bit-select multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
module mux24 #(
    parameter int SEL_W = 4
) (
    input  logic [(2**SEL_W)-1:0] in,
    input  logic [SEL_W-1:0]      sel,
    output logic                  out
);

    assign out = in[sel];

endmodule
`default_nettype wire

// File: rtl/mux24_sel_seq.sv
`default_nettype none
// ============================================================================
// Module   : mux24_sel_seq
// Purpose  : Loads a word onto mux24 and steps its select to emit a bit stream.
// Revision : 1.0 - initial release
// ============================================================================
module mux24_sel_seq #(
    parameter int SEL_W     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [(2**SEL_W)-1:0] in_data,
    input  logic [SEL_W-1:0]      in_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [(2**SEL_W)-1:0] mux_in,
    output logic [SEL_W-1:0]      mux_sel,
    input  logic                  mux_out,
    output logic                  bit_out,
    output logic                  bit_valid,
    input  logic                  bit_ready,
    output logic                  bit_last,
    output logic                  busy
);

    import mux24_pkg::*;

    seq_state_t            r_state;
    seq_state_t            w_state_nxt;
    logic [(2**SEL_W)-1:0] r_mux_in;
    logic [SEL_W-1:0]      r_mux_sel;
    logic [SEL_W-1:0]      r_cnt;
    logic [SEL_W-1:0]      r_len;
    logic [SEL_W-1:0]      w_first_sel;
    logic [SEL_W-1:0]      w_next_sel;
    logic                  w_accept;
    logic                  w_take;

    // Serial order only changes where the select starts and which way it walks.
    if (MSB_FIRST != 0) begin : g_msb_first
        assign w_first_sel = in_len;
        assign w_next_sel  = r_mux_sel - 1'b1;
    end else begin : g_lsb_first
        assign w_first_sel = '0;
        assign w_next_sel  = r_mux_sel + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        bit_valid   = 1'b0;
        bit_last    = 1'b0;
        busy        = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    in_ready = 1'b1;
                end
                SHIFT: begin
                    bit_valid = 1'b1;
                    busy      = 1'b1;
                    bit_last  = (r_cnt == r_len);
                    // Next word may load on the last beat so the stream has no bubble.
                    in_ready  = (r_cnt == r_len) && bit_ready;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
        w_accept = in_valid && in_ready;
        w_take   = bit_valid && bit_ready;
        if (w_accept) begin
            w_state_nxt = SHIFT;
        end else if (w_take && bit_last) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mux_in  <= '0;
            r_mux_sel <= '0;
            r_cnt     <= '0;
            r_len     <= '0;
        end else if (w_accept) begin
            r_mux_in  <= in_data;
            r_len     <= in_len;
            r_cnt     <= '0;
            r_mux_sel <= w_first_sel;
        end else if (w_take && !bit_last) begin
            r_cnt     <= r_cnt + 1'b1;
            r_mux_sel <= w_next_sel;
        end
    end

    assign mux_in  = r_mux_in;
    assign mux_sel = r_mux_sel;
    assign bit_out = mux_out;

endmodule
`default_nettype wire

// File: tb/tb_mux24_sel_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux24_sel_seq
// Purpose  : Self-checking bench: LSB-first and MSB-first sequencers, each on a mux24.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux24_sel_seq;

    localparam int SEL_W = 4;
    localparam int DW    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] in_data   [2];
    logic [3:0]    in_len    [2];
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [DW-1:0] mux_in    [2];
    logic [3:0]    mux_sel   [2];
    logic          mux_out   [2];
    logic          bit_out   [2];
    logic          bit_valid [2];
    logic          bit_ready [2];
    logic          bit_last  [2];
    logic          busy      [2];

    // Unit 0 is LSB-first, unit 1 is MSB-first.
    mux24_sel_seq #(.SEL_W(SEL_W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_len(in_len[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .mux_in(mux_in[0]),
        .mux_sel(mux_sel[0]), .mux_out(mux_out[0]), .bit_out(bit_out[0]),
        .bit_valid(bit_valid[0]), .bit_ready(bit_ready[0]), .bit_last(bit_last[0]),
        .busy(busy[0])
    );
    mux24 #(.SEL_W(SEL_W)) u_mux_lsb (.in(mux_in[0]), .sel(mux_sel[0]), .out(mux_out[0]));

    mux24_sel_seq #(.SEL_W(SEL_W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_len(in_len[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .mux_in(mux_in[1]),
        .mux_sel(mux_sel[1]), .mux_out(mux_out[1]), .bit_out(bit_out[1]),
        .bit_valid(bit_valid[1]), .bit_ready(bit_ready[1]), .bit_last(bit_last[1]),
        .busy(busy[1])
    );
    mux24 #(.SEL_W(SEL_W)) u_mux_msb (.in(mux_in[1]), .sel(mux_sel[1]), .out(mux_out[1]));

    int n_checks = 0;
    int n_fail   = 0;

    // Beats observed by collect()
    int         got_n;
    logic       got_bit  [64];
    logic [3:0] got_sel  [64];
    logic       got_last [64];
    int         got_cyc  [64];
    int         hold_err;
    bit         timed_out;

    // Reference stream: bit k of the word goes out as beat k (LSB-first) or beat len-k.
    int         exp_n;
    logic       exp_bit [16];
    logic [3:0] exp_sel [16];

    function automatic void model(input logic [15:0] d, input logic [3:0] len, input bit msb);
        logic [3:0] idx;
        exp_n = int'(len) + 1;
        for (int i = 0; i < exp_n; i++) begin
            idx        = msb ? 4'(int'(len) - i) : 4'(i);
            exp_bit[i] = d[idx];
            exp_sel[i] = idx;
        end
    endfunction

    // Entered and left just after a rising edge.
    task automatic offer(input bit u, input logic [15:0] d, input logic [3:0] len, output bit ok);
        in_data[u]  = d;
        in_len[u]   = len;
        in_valid[u] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (in_ready[u] === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid[u] = 1'b0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready
    task automatic collect(input bit u, input int mode, input int max_cyc);
        logic       s_bit = 1'b0;
        logic [3:0] s_sel = '0;
        logic [15:0] s_in = '0;
        bit stalled = 1'b0;
        bit done    = 1'b0;
        got_n = 0; hold_err = 0; timed_out = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            case (mode)
                0:       bit_ready[u] = 1'b1;
                1:       bit_ready[u] = (c % 3 == 0);
                default: bit_ready[u] = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (stalled && (bit_valid[u] !== 1'b1 || bit_out[u] !== s_bit ||
                            mux_sel[u] !== s_sel || mux_in[u] !== s_in))
                hold_err++;
            stalled = 1'b0;
            if (bit_valid[u] === 1'b1 && bit_ready[u] === 1'b1) begin
                if (got_n < 64) begin
                    got_bit[got_n]  = bit_out[u];
                    got_sel[got_n]  = mux_sel[u];
                    got_last[got_n] = bit_last[u];
                    got_cyc[got_n]  = c;
                    got_n++;
                end
                if (bit_last[u] === 1'b1) done = 1'b1;
            end else if (bit_valid[u] === 1'b1) begin
                stalled = 1'b1;
                s_bit = bit_out[u]; s_sel = mux_sel[u]; s_in = mux_in[u];
            end
            @(posedge clk); #1;
        end
        timed_out = !done;
        bit_ready[u] = 1'b1;
    endtask

    task automatic test_reset;
        bit ok0, ok1;
        bit_ready[0] = 1'b0; bit_ready[1] = 1'b0;
        offer(1'b0, 16'h1234, 4'd12, ok0);
        offer(1'b1, 16'hBEEF, 4'd9, ok1);
        n_checks++;
        if (!(ok0 && ok1)) begin n_fail++; $display("FAIL reset_setup_accept got %0b%0b exp 11", ok0, ok1); end
        bit_ready[0] = 1'b1; bit_ready[1] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bit_valid[0], in_ready[0], bit_valid[1], in_ready[1], busy[0], busy[1]} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d valid/ready/busy got %b%b%b%b%b%b exp 000000", c,
                         bit_valid[0], in_ready[0], bit_valid[1], in_ready[1], busy[0], busy[1]);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if (in_ready[u] !== 1'b1 || mux_sel[u] !== 4'd0 || mux_in[u] !== 16'h0 || busy[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release unit %0d ready=%b sel=%0d in=%h busy=%b exp 1 0 0000 0",
                         u, in_ready[u], mux_sel[u], mux_in[u], busy[u]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lsb_full;
        bit ok;
        model(16'hA5C3, 4'd15, 1'b0);
        offer(1'b0, 16'hA5C3, 4'd15, ok);
        collect(1'b0, 0, 100);
        n_checks++;
        if (!ok || timed_out || got_n !== 16) begin
            n_fail++; $display("FAIL lsb_full_count ok=%0b timeout=%0b beats=%0d exp 16", ok, timed_out, got_n);
        end
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            n_checks++;
            if ({got_bit[i], got_sel[i], got_last[i]} !== {exp_bit[i], exp_sel[i], 1'(i == exp_n - 1)}) begin
                n_fail++;
                $display("FAIL lsb_full_beat %0d got bit=%b sel=%0d last=%b exp bit=%b sel=%0d",
                         i, got_bit[i], got_sel[i], got_last[i], exp_bit[i], exp_sel[i]);
            end
        end
        n_checks++;
        if (got_n == 16 && (got_cyc[0] !== 0 || got_cyc[15] !== 15)) begin
            n_fail++; $display("FAIL lsb_full_timing first=%0d last=%0d exp 0 15", got_cyc[0], got_cyc[15]);
        end
    endtask

    task automatic test_msb_short;
        bit ok;
        model(16'h0005, 4'd3, 1'b1);
        offer(1'b1, 16'h0005, 4'd3, ok);
        collect(1'b1, 0, 50);
        n_checks++;
        if (!ok || timed_out || got_n !== 4) begin
            n_fail++; $display("FAIL msb_short_count ok=%0b timeout=%0b beats=%0d exp 4", ok, timed_out, got_n);
        end
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            n_checks++;
            if ({got_bit[i], got_sel[i], got_last[i]} !== {exp_bit[i], exp_sel[i], 1'(i == exp_n - 1)}) begin
                n_fail++;
                $display("FAIL msb_short_beat %0d got bit=%b sel=%0d last=%b exp bit=%b sel=%0d",
                         i, got_bit[i], got_sel[i], got_last[i], exp_bit[i], exp_sel[i]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (in_ready[1] !== 1'b1 || busy[1] !== 1'b0 || bit_valid[1] !== 1'b0) begin
            n_fail++; $display("FAIL msb_short_idle ready=%b busy=%b valid=%b exp 1 0 0", in_ready[1], busy[1], bit_valid[1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        bit ok;
        model(16'h00FF, 4'd7, 1'b0);
        offer(1'b0, 16'h00FF, 4'd7, ok);
        collect(1'b0, 1, 100);
        n_checks++;
        if (!ok || timed_out || got_n !== 8 || hold_err !== 0) begin
            n_fail++; $display("FAIL bp_count ok=%0b timeout=%0b beats=%0d hold_err=%0d exp 8 beats 0 errs",
                               ok, timed_out, got_n, hold_err);
        end
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            n_checks++;
            if ({got_bit[i], got_sel[i], got_last[i]} !== {1'b1, exp_sel[i], 1'(i == exp_n - 1)}) begin
                n_fail++;
                $display("FAIL bp_beat %0d got bit=%b sel=%0d last=%b exp bit=1 sel=%0d",
                         i, got_bit[i], got_sel[i], got_last[i], exp_sel[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        in_data[0] = 16'h0001; in_len[0] = 4'd0; in_valid[0] = 1'b1; bit_ready[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_a_ready got %b exp 1", in_ready[0]); end
        @(posedge clk); #1;
        in_data[0] = 16'h8000; in_len[0] = 4'd15;
        @(negedge clk);
        n_checks++;
        if ({bit_valid[0], bit_last[0], bit_out[0], in_ready[0]} !== 4'b1111) begin
            n_fail++; $display("FAIL b2b_a_beat valid/last/bit/ready got %b%b%b%b exp 1111",
                               bit_valid[0], bit_last[0], bit_out[0], in_ready[0]);
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        model(16'h8000, 4'd15, 1'b0);
        collect(1'b0, 0, 100);
        n_checks++;
        if (timed_out || got_n !== 16 || got_cyc[0] !== 0) begin
            n_fail++; $display("FAIL b2b_b_count timeout=%0b beats=%0d first_cyc=%0d exp 16 beats at 0",
                               timed_out, got_n, got_cyc[0]);
        end
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            n_checks++;
            if ({got_bit[i], got_sel[i], got_last[i]} !== {exp_bit[i], exp_sel[i], 1'(i == exp_n - 1)}) begin
                n_fail++;
                $display("FAIL b2b_b_beat %0d got bit=%b sel=%0d last=%b exp bit=%b sel=%0d",
                         i, got_bit[i], got_sel[i], got_last[i], exp_bit[i], exp_sel[i]);
            end
        end
    endtask

    task automatic test_ignore_abort;
        bit ok;
        model(16'h6C3A, 4'd15, 1'b0);
        offer(1'b0, 16'h6C3A, 4'd15, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL abort_accept got 0 exp 1"); end
        for (int i = 0; i < 5; i++) begin
            bit_ready[0] = 1'b1;
            in_valid[0]  = (i == 1 || i == 2);
            in_data[0]   = 16'hFFFF;
            in_len[0]    = 4'hF;
            @(negedge clk);
            n_checks++;
            if ({bit_valid[0], in_ready[0], mux_in[0], bit_out[0], mux_sel[0]} !==
                {1'b1, 1'b0, 16'h6C3A, exp_bit[i], exp_sel[i]}) begin
                n_fail++;
                $display("FAIL ignore_beat %0d valid=%b ready=%b in=%h bit=%b sel=%0d exp 1 0 6c3a %b %0d",
                         i, bit_valid[0], in_ready[0], mux_in[0], bit_out[0], mux_sel[0], exp_bit[i], exp_sel[i]);
            end
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (bit_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
                n_fail++; $display("FAIL abort_after cyc %0d valid=%b ready=%b busy=%b exp 0 1 0",
                                   c, bit_valid[0], in_ready[0], busy[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random;
        bit ok;
        bit u;
        logic [15:0] d;
        logic [3:0]  len;
        for (int k = 0; k < 24; k++) begin
            u   = 1'($urandom_range(0, 1));
            d   = 16'($urandom);
            len = 4'($urandom_range(0, 15));
            model(d, len, u);
            offer(u, d, len, ok);
            collect(u, 2, 400);
            n_checks++;
            if (!ok || timed_out || got_n !== exp_n || hold_err !== 0) begin
                n_fail++;
                $display("FAIL rand_word %0d unit %0d d=%h len=%0d ok=%0b timeout=%0b beats=%0d exp %0d hold_err=%0d",
                         k, u, d, len, ok, timed_out, got_n, exp_n, hold_err);
            end
            for (int i = 0; i < exp_n && i < got_n; i++) begin
                n_checks++;
                if ({got_bit[i], got_sel[i], got_last[i]} !== {exp_bit[i], exp_sel[i], 1'(i == exp_n - 1)}) begin
                    n_fail++;
                    $display("FAIL rand_beat w%0d b%0d got bit=%b sel=%0d last=%b exp bit=%b sel=%0d",
                             k, i, got_bit[i], got_sel[i], got_last[i], exp_bit[i], exp_sel[i]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        foreach (in_valid[u]) begin
            in_valid[u]  = 1'b0;
            bit_ready[u] = 1'b0;
            in_data[u]   = '0;
            in_len[u]    = '0;
        end
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        test_reset;
        test_lsb_full;
        test_msb_short;
        test_backpressure;
        test_back_to_back;
        test_ignore_abort;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
